proc_control_unit: RTL
======================

Name: proc_control_unit

Overview:
Multi-cycle FSM controller for the ProjectB processor. It holds the instruction register and sequences the 7-bit PC counter through its up and clear inputs. It drives the data-memory, register-file and ALU control lines for each instruction. It sits between the instruction ROM and PC counter on one side and the datapath (RAM, register file, ALU) on the other.

Parameters:
INSTR_W, 16, instruction width; opcode is IR[15:12]
D_ADDR_W, 8, data memory address width
RF_ADDR_W, 4, register-file address width

Ports:
clk  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous active-high reset
instr_in  in  16  instruction ROM output; valid for the current PC during Fetch
pc_clr  out  1  to PC counter clear
pc_up  out  1  to PC counter up
ir_out  out  16  current instruction register contents
d_addr  out  8  data memory address
d_wr  out  1  data memory write enable
rf_s  out  1  register-file write mux select (1 = RAM read data, 0 = ALU result)
rf_w_addr  out  4  register-file write address
rf_w_en  out  1  register-file write enable
rf_ra_addr  out  4  register-file read port A address
rf_rb_addr  out  4  register-file read port B address
alu_s  out  3  ALU function select
state_out  out  4  state encoding, for display and debug
halted  out  1  high while in Halt

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port is clk, reset port is reset.
- Reset forces state Init and IR = 0 immediately, regardless of clock. Reset mid-instruction abandons that instruction.
- All outputs are Moore outputs, decoded from registered state and IR. In Init: pc_clr = 1 and every other control output is 0. Address outputs are don't-care outside the states listed below and are driven 0.
- Init -> Fetch, unconditionally.
- Fetch: IR <= instr_in at the clock edge, pc_up = 1 for exactly one cycle. Next state is Decode.
- Decode: no writes. Next state by IR[15:12]:
  - 0000 NOOP
  - 0001 Store
  - 0010 LoadA
  - 0011 Add
  - 0100 Sub
  - 0101 Halt
  - Any other opcode goes to NOOP.
- NOOP: all enables 0. Next state Fetch.
- LoadA: d_addr = IR[11:4], rf_w_addr = IR[3:0], rf_s = 1, rf_w_en = 0. This cycle covers the synchronous RAM read latency. Next state LoadB.
- LoadB: same d_addr, rf_w_addr and rf_s as LoadA, with rf_w_en = 1. Next state Fetch.
- Store: d_addr = IR[7:0], rf_ra_addr = IR[11:8], d_wr = 1 for exactly one cycle. Next state Fetch.
- Add: rf_ra_addr = IR[11:8], rf_rb_addr = IR[7:4], rf_w_addr = IR[3:0], alu_s = 3'd1, rf_s = 0, rf_w_en = 1. Next state Fetch.
- Sub: as Add, with alu_s = 3'd2.
- alu_s = 3'd0 (pass-through) in every state other than Add and Sub.
- Halt: halted = 1, all enables 0, pc_up = 0. Halt is absorbing; only reset exits it.
- Cycles per instruction:
  - NOOP, Store, Add, Sub: 3 (Fetch, Decode, Execute)
  - Load: 4
  - Halt: reached after 2 cycles, then held
- PC wrap from 127 to 0 belongs to the counter; the controller ignores it.
- Write exclusivity: d_wr and rf_w_en are never high in the same cycle, and are never high in Init, Fetch, Decode or Halt.
- state_out encoding:
  - Init 0, Fetch 1, Decode 2, NOOP 3
  - LoadA 4, LoadB 5, Store 6, Add 7
  - Sub 8, Halt 9

Decomposition:
- Package proc_pkg:
  - state_t enum with the encodings above
  - opcode localparams (OP_NOOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_HALT)
  - ALU select constants (ALU_PASS = 0, ALU_ADD = 1, ALU_SUB = 2)
- One sub-module, instr_reg: a 16-bit register with load enable and asynchronous reset, instantiated for the IR.
- Next-state logic and output decode remain in proc_control_unit.

Test Plan:
- Reset asserted mid-cycle -> state_out = 0 and pc_clr = 1 without waiting for an edge. After release: Fetch on the next edge, pc_up = 1 for one cycle, then Decode.
- instr_in = 16'h3123 -> Fetch, then Decode, then Add with rf_ra_addr = 1, rf_rb_addr = 2, rf_w_addr = 3, alu_s = 1, rf_w_en = 1 for one cycle, then Fetch.
- instr_in = 16'h21A5 -> LoadA with d_addr = 8'h1A and rf_w_en = 0. Then LoadB with d_addr = 8'h1A, rf_s = 1, rf_w_addr = 5, rf_w_en = 1. Then Fetch.
- instr_in = 16'h1742 -> Store with d_addr = 8'h42, rf_ra_addr = 7, d_wr = 1 for exactly one cycle. Then 16'h4567 -> Sub with alu_s = 2, rf_w_addr = 7.
- instr_in = 16'h5000 -> Halt. halted = 1 and pc_up, d_wr and rf_w_en stay 0 for 20 cycles despite instr_in changing. Reset then returns to Init.
- instr_in = 16'hF123 -> treated as NOOP: no d_wr or rf_w_en pulse, Fetch after 3 cycles. Reset asserted during LoadA -> no LoadB write occurs, and the next state is Init.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and constants for the ProjectB control unit:
//               FSM state encoding, opcodes and ALU function selects.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    // Numeric values are visible on state_out, so the encoding is fixed.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOADA  = 4'd4,
        ST_LOADB  = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    // Opcodes held in IR[15:12].
    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    // ALU function selects.
    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/instr_reg.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg
// Description : Instruction register with load enable, async active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when load is high; reset clears immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : instr_reg
`default_nettype wire

// File: rtl/proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_unit
// Description : Multi-cycle FSM controller for the ProjectB processor. Holds
//               the IR, sequences the PC counter and drives the data-memory,
//               register-file and ALU control lines. All control outputs are
//               registered and derived from the state being entered, so they
//               are a pure function of the registered state and IR.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_control_unit
    import proc_pkg::*;
#(
    parameter int INSTR_W   = 16,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr_in,
    output logic                 pc_clr,
    output logic                 pc_up,
    output logic [INSTR_W-1:0]   ir_out,
    output logic [D_ADDR_W-1:0]  d_addr,
    output logic                 d_wr,
    output logic                 rf_s,
    output logic [RF_ADDR_W-1:0] rf_w_addr,
    output logic                 rf_w_en,
    output logic [RF_ADDR_W-1:0] rf_ra_addr,
    output logic [RF_ADDR_W-1:0] rf_rb_addr,
    output logic [2:0]           alu_s,
    output logic [3:0]           state_out,
    output logic                 halted
);

    state_t             state;
    state_t             next_state;
    logic [INSTR_W-1:0] ir;
    logic               ir_load;
    logic [11:0]        next_fields;   // operand fields of the IR as it will be next cycle

    assign ir_load = (state == ST_FETCH);

    instr_reg #(
        .WIDTH (INSTR_W)
    ) u_instr_reg (
        .clk   (clk),
        .reset (reset),
        .load  (ir_load),
        .d     (instr_in),
        .q     (ir)
    );

    assign ir_out    = ir;
    assign state_out = state;

    // The outputs for the next state must see the freshly fetched word.
    assign next_fields = ir_load ? instr_in[11:0] : ir[11:0];

    // Next-state selection; Decode dispatches on the opcode in the IR.
    always_comb begin
        next_state = ST_INIT;
        case (state)
            ST_INIT:   next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: begin
                case (ir[INSTR_W-1 -: 4])
                    OP_NOOP:  next_state = ST_NOOP;
                    OP_STORE: next_state = ST_STORE;
                    OP_LOAD:  next_state = ST_LOADA;
                    OP_ADD:   next_state = ST_ADD;
                    OP_SUB:   next_state = ST_SUB;
                    OP_HALT:  next_state = ST_HALT;
                    default:  next_state = ST_NOOP;
                endcase
            end
            ST_LOADA:  next_state = ST_LOADB;
            ST_HALT:   next_state = ST_HALT;
            ST_NOOP, ST_LOADB, ST_STORE, ST_ADD, ST_SUB:
                       next_state = ST_FETCH;
            default:   next_state = ST_INIT;
        endcase
    end

    // State register plus registered control outputs for the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            pc_clr     <= 1'b1;
            pc_up      <= 1'b0;
            d_addr     <= '0;
            d_wr       <= 1'b0;
            rf_s       <= 1'b0;
            rf_w_addr  <= '0;
            rf_w_en    <= 1'b0;
            rf_ra_addr <= '0;
            rf_rb_addr <= '0;
            alu_s      <= ALU_PASS;
            halted     <= 1'b0;
        end else begin
            state      <= next_state;
            pc_clr     <= 1'b0;
            pc_up      <= 1'b0;
            d_addr     <= '0;
            d_wr       <= 1'b0;
            rf_s       <= 1'b0;
            rf_w_addr  <= '0;
            rf_w_en    <= 1'b0;
            rf_ra_addr <= '0;
            rf_rb_addr <= '0;
            alu_s      <= ALU_PASS;
            halted     <= 1'b0;
            case (next_state)
                ST_INIT:  pc_clr <= 1'b1;
                ST_FETCH: pc_up  <= 1'b1;
                ST_LOADA: begin
                    d_addr    <= next_fields[11:4];
                    rf_w_addr <= next_fields[3:0];
                    rf_s      <= 1'b1;
                end
                ST_LOADB: begin
                    d_addr    <= next_fields[11:4];
                    rf_w_addr <= next_fields[3:0];
                    rf_s      <= 1'b1;
                    rf_w_en   <= 1'b1;
                end
                ST_STORE: begin
                    d_addr     <= next_fields[7:0];
                    rf_ra_addr <= next_fields[11:8];
                    d_wr       <= 1'b1;
                end
                ST_ADD, ST_SUB: begin
                    rf_ra_addr <= next_fields[11:8];
                    rf_rb_addr <= next_fields[7:4];
                    rf_w_addr  <= next_fields[3:0];
                    rf_w_en    <= 1'b1;
                    alu_s      <= (next_state == ST_ADD) ? ALU_ADD : ALU_SUB;
                end
                ST_HALT:  halted <= 1'b1;
                default:  ;
            endcase
        end
    end

endmodule : proc_control_unit
`default_nettype wire
